// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO.
package sync_fifo_pkg;

    // Pointer/count width: address bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Binary wrap counter used as a FIFO read or write pointer.
module fifo_ptr #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= r_ptr + WIDTH'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count, threshold flags and sticky error flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_LEVEL   = DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     wr,
    input  logic                     rd,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ptr_w(DEPTH)-1:0]  count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;
    localparam logic [PW-1:0] AF_CMP = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CMP = PW'(AE_LEVEL);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("sync_fifo: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [PW-1:0]         w_wr_ptr;
    logic [PW-1:0]         w_rd_ptr;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [PW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    assign w_full  = (w_wr_ptr[AW] != w_rd_ptr[AW]) && (w_wr_ptr[AW-1:0] == w_rd_ptr[AW-1:0]);
    assign w_empty = (w_wr_ptr == w_rd_ptr);
    // clr wins over both requests, so neither pointer nor storage moves on a flush.
    assign w_wr_en = wr & ~w_full & ~clr;
    assign w_rd_en = rd & ~w_empty & ~clr;

    fifo_ptr #(
        .WIDTH (PW)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (w_wr_en),
        .ptr   (w_wr_ptr)
    );

    fifo_ptr #(
        .WIDTH (PW)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (w_rd_en),
        .ptr   (w_rd_ptr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (w_wr_en && !w_rd_en) begin
            r_count <= r_count + PW'(1);
        end else if (w_rd_en && !w_wr_en) begin
            r_count <= r_count - PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign dout         = r_mem[w_rd_ptr[AW-1:0]];
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AF_CMP);
    assign almost_empty = (r_count <= AE_CMP);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // The registered count must track the pointer difference modulo 2*DEPTH.
    a_count_matches_ptrs : assert property (
        @(posedge clk) disable iff (reset) (r_count == (w_wr_ptr - w_rd_ptr))
    );

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO: the same-domain counterpart of our dual-clock FIFO, used where producer and consumer share one clock. Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. Read data is show-ahead: the head entry is visible on `dout` while `empty` is low.

## Interface
- `DATA_WIDTH`, default 8: width of each entry.
- `DEPTH`, default 16: number of entries. Must be a power of 2 and at least 2.
- `AF_LEVEL`, default DEPTH-2: `almost_full` asserts when count >= AF_LEVEL. Legal range is 1..DEPTH.
- `AE_LEVEL`, default 2: `almost_empty` asserts when count <= AE_LEVEL. Legal range is 0..DEPTH-1.
- `clk`  in  1  the single clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous flush. Empties the FIFO and clears the error flags.
- `din`  in  DATA_WIDTH  write data.
- `wr`  in  1  write request.
- `rd`  in  1  read request. Pops the head entry.
- `dout`  out  DATA_WIDTH  head entry. Valid when `empty`=0.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count >= AF_LEVEL.
- `almost_empty`  out  1  count <= AE_LEVEL.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky. Set by a write attempted while full.
- `underflow`  out  1  sticky. Set by a read attempted while empty.

## Operation
- Internal signals:
  - `wr_en = wr & ~full`
  - `rd_en = rd & ~empty`
  - A rejected request has no effect on pointers, storage or count.
- Pointers:
  - Write and read pointers are binary, $clog2(DEPTH)+1 bits wide.
  - The low bits address storage. The MSB is a wrap bit.
  - `full` when the MSBs differ and the low bits are equal. `empty` when the pointers are equal.
  - The pointers wrap modulo 2·DEPTH with no special case.
- `count`:
  - Registered. Increments on `wr_en & ~rd_en`, decrements on `rd_en & ~wr_en`, and is unchanged when both or neither fire.
  - `count` always equals `wr_ptr - rd_ptr`, taken modulo 2·DEPTH. Verification asserts this.
- Simultaneous read and write:
  - When 0 < count < DEPTH, both are accepted and count is unchanged.
  - When full, only the read is accepted and `overflow` sets.
  - When empty, only the write is accepted and `underflow` sets.
  - There is no write-through bypass: a word written while empty becomes visible on `dout` the cycle after the write.
- `dout` is a combinational read of storage at the read pointer. Its value while `empty`=1 is the stale storage content and carries no meaning.
- Storage is a DEPTH × DATA_WIDTH register array. It is written only on `wr_en` and reset to 0.
- `clr`:
  - Takes priority over `wr` and `rd` in the same cycle.
  - Next cycle: both pointers are 0, count is 0, and `overflow`/`underflow` are 0. Storage is not cleared.
- Error flags:
  - `overflow` sets on `wr & full & ~clr`. `underflow` sets on `rd & empty & ~clr`.
  - Both hold until `clr` or `reset`.

## Timing
- Reset values: pointers 0, count 0, storage 0.
  - Outputs: `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0 (AF_LEVEL ≥ 1), `overflow`=0, `underflow`=0, `dout`=0.
- Reset is asynchronous. Assertion in mid-operation clears all state immediately, whether or not a read or write is in flight.
- Write latency:
  - A write sampled at edge N raises count, drops `empty` and updates `dout` (if the FIFO was empty) after edge N.
  - The flags are decoded from the registered pointers and count, so they reflect edge N in the same cycle as count.
- Read latency: a read sampled at edge N advances `dout` to the next entry after edge N.
- Sustained throughput: one write and one read per cycle.
- No combinational path from `wr`/`rd` to any output.

## Structure
- Package `sync_fifo_pkg` holds a `ptr_w(depth)` function returning $clog2(depth)+1. It is used for the pointer and `count` widths.
- Parameter legality is checked by elaboration-time assertions:
  - DEPTH is a power of 2.
  - AF_LEVEL and AE_LEVEL are within their legal ranges.
- One sub-module: `fifo_ptr`, a parametrised binary wrap counter with `clk`, `reset`, `clr`, `en` and `ptr` ports. It is instantiated twice, once for the write pointer and once for the read pointer.
- Storage, flag decode and error flags live in the top level.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
- Fill and drain:
  - Reset, then write 0x00..0x0F on consecutive cycles. After the 16th write: `full`=1, count=16, `almost_full`=1.
  - Read 16 times: `dout` sequence is 0x00..0x0F, then `empty`=1, count=0.
- Overflow: while full, pulse `wr` with din=0xAA. Count stays 16 and `overflow`=1 and stays set. Head is still 0x00. `clr` → `overflow`=0, `empty`=1.
- Underflow with simultaneous write: while empty, assert `rd` and `wr` (din=0x55) together. Next cycle: count=1, `dout`=0x55, `underflow`=1.
- Wrap-around streaming: with count=8, run 100 cycles of simultaneous `rd`/`wr` using an incrementing pattern. Count stays 8 throughout, output order matches a scoreboard, and the pointers wrap at least 6 times.
- Thresholds: step count 0→16→0 one entry at a time.
  - `almost_empty` is 1 exactly for counts 0..2.
  - `almost_full` is 1 exactly for counts 14..16.
- Reset mid-operation: assert `reset` asynchronously between edges while count=9. All outputs immediately take their reset values. The first write after release gives `dout`=that data and count=1.
